// File: rtl/ram_req_arbiter.sv
// Round-robin arbiter sharing one DRAM-model read/write port among NREQ requesters.
// Completions return in issue order per channel and are routed back through ID FIFOs.
module ram_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*64-1:0]   req_addr,
    input  logic [NREQ*64-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_rvalid,
    output logic [NREQ-1:0]      rsp_wvalid,
    output logic [63:0]          rsp_rdata,
    output logic                 ram_rvalid,
    output logic [63:0]          ram_raddr,
    output logic                 ram_wvalid,
    output logic [63:0]          ram_waddr,
    output logic [63:0]          ram_wdata,
    input  logic                 ram_readReady,
    input  logic                 ram_writeReady,
    input  logic                 ram_readfin,
    input  logic                 ram_writefin,
    input  logic [63:0]          ram_rdata,
    output logic                 err_sticky
);
    localparam int unsigned CW = $clog2(MAX_OUT + 1);
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic {ChIdle, ChPend} ch_state_e;

    ch_state_e      r_state_q, w_state_q;
    logic [CW-1:0]  r_cnt_q, w_cnt_q;
    logic [PW-1:0]  r_wptr_q, r_rptr_q, w_wptr_q, w_rptr_q;
    logic [IDW-1:0] r_fifo_q [MAX_OUT];
    logic [IDW-1:0] w_fifo_q [MAX_OUT];
    logic [IDW-1:0] rr_q;

    logic            r_free, w_free, r_room, w_room;
    logic [NREQ-1:0] elig;
    logic            gnt_any, r_gnt, w_gnt;
    logic [IDW-1:0]  gnt_id;
    logic [63:0]     gnt_addr, gnt_wdata;
    logic            r_pop, w_pop;

    // A channel can take a new grant if empty or if its pending request leaves this edge.
    assign r_free = (r_state_q == ChIdle) || ram_readReady;
    assign w_free = (w_state_q == ChIdle) || ram_writeReady;
    assign r_room = r_cnt_q < CW'(MAX_OUT);
    assign w_room = w_cnt_q < CW'(MAX_OUT);

    assign ram_rvalid = (r_state_q == ChPend);
    assign ram_wvalid = (w_state_q == ChPend);

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] && (req_write[i] ? (w_free && w_room) : (r_free && r_room));
        end
    end

    always_comb begin
        logic [IDW:0] sum;
        gnt_any = 1'b0;
        gnt_id  = '0;
        sum     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            if (!gnt_any && elig[sum[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = sum[IDW-1:0];
            end
        end
        // Keep the combinational grant quiet while reset is held.
        if (!rst_n) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign r_gnt     = gnt_any && !req_write[gnt_id];
    assign w_gnt     = gnt_any && req_write[gnt_id];
    assign gnt_addr  = req_addr[{gnt_id, 6'd0} +: 64];
    assign gnt_wdata = req_wdata[{gnt_id, 6'd0} +: 64];
    // A fin with nothing outstanding is dropped and flagged instead.
    assign r_pop     = ram_readfin && (r_cnt_q != '0);
    assign w_pop     = ram_writefin && (w_cnt_q != '0);

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= ChIdle;
            w_state_q  <= ChIdle;
            ram_raddr  <= '0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            r_cnt_q    <= '0;
            w_cnt_q    <= '0;
            r_wptr_q   <= '0;
            r_rptr_q   <= '0;
            w_wptr_q   <= '0;
            w_rptr_q   <= '0;
            rr_q       <= '0;
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                r_fifo_q[i] <= '0;
                w_fifo_q[i] <= '0;
            end
            rsp_rvalid <= '0;
            rsp_wvalid <= '0;
            rsp_rdata  <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (r_gnt) begin
                r_state_q          <= ChPend;
                ram_raddr          <= gnt_addr;
                r_fifo_q[r_wptr_q] <= gnt_id;
                r_wptr_q           <= ptr_next(r_wptr_q);
            end else if (ram_rvalid && ram_readReady) begin
                r_state_q <= ChIdle;
            end

            if (w_gnt) begin
                w_state_q          <= ChPend;
                ram_waddr          <= gnt_addr;
                ram_wdata          <= gnt_wdata;
                w_fifo_q[w_wptr_q] <= gnt_id;
                w_wptr_q           <= ptr_next(w_wptr_q);
            end else if (ram_wvalid && ram_writeReady) begin
                w_state_q <= ChIdle;
            end

            if (r_gnt && !r_pop) begin
                r_cnt_q <= r_cnt_q + CW'(1);
            end else if (!r_gnt && r_pop) begin
                r_cnt_q <= r_cnt_q - CW'(1);
            end
            if (w_gnt && !w_pop) begin
                w_cnt_q <= w_cnt_q + CW'(1);
            end else if (!w_gnt && w_pop) begin
                w_cnt_q <= w_cnt_q - CW'(1);
            end

            rsp_rvalid <= '0;
            rsp_wvalid <= '0;
            if (r_pop) begin
                rsp_rvalid[r_fifo_q[r_rptr_q]] <= 1'b1;
                rsp_rdata                      <= ram_rdata;
                r_rptr_q                       <= ptr_next(r_rptr_q);
            end
            if (w_pop) begin
                rsp_wvalid[w_fifo_q[w_rptr_q]] <= 1'b1;
                w_rptr_q                       <= ptr_next(w_rptr_q);
            end

            if ((ram_readfin && !r_pop) || (ram_writefin && !w_pop)) begin
                err_sticky <= 1'b1;
            end

            if (gnt_any) begin
                rr_q <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
            end
        end
    end
endmodule
